cv32e40p_tmr_fault_ctrl: RTL
============================

CV32E40P_TMR_FAULT_CTRL -- requirements
Module: cv32e40p_tmr_fault_ctrl

Interface
REQ-001 The block SHALL have parameter N_VOTERS, default 4: number of TMR voters whose faulty flags are monitored.
REQ-002 The block SHALL have parameter RECOVER_CYCLES, default 4: cycles resync_o/stall_o are held per recovery (1..255).
REQ-003 The block SHALL have parameter CHECK_CYCLES, default 8: fault-free observation window after recovery (1..255).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 2: recoveries allowed before the alarm is raised (1..15).
REQ-005 The block SHALL have parameter CNT_WIDTH, default 16: width of the fault event counter.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port fault_i, input, N_VOTERS: per-voter faulty flag, bit i from voter i.
REQ-009 The block SHALL have port clear_i, input, 1: software/debug clear of the alarm.
REQ-010 The block SHALL have port resync_o, output, 1: request to resynchronise the replicas from the voted state.
REQ-011 The block SHALL have port stall_o, output, 1: holds the pipeline while recovering or alarmed.
REQ-012 The block SHALL have port alarm_o, output, 1: sticky permanent-fault indication.
REQ-013 The block SHALL have port retry_cnt_o, output, 4: recoveries in the current fault episode.
REQ-014 The block SHALL have port fault_cnt_o, output, CNT_WIDTH: total fault events since reset.
REQ-015 The block SHALL have port fault_mask_o, output, N_VOTERS: sticky OR of fault_i (see Configuration).

Function
REQ-016 The block SHALL have FSM states IDLE, RECOVER, CHECK and ALARM; resync_o, stall_o and alarm_o SHALL be decoded from the state register only (Moore).
REQ-017 A fault event SHALL be a cycle with |fault_i=1 while in IDLE or CHECK; fault_i SHALL be ignored in RECOVER and ALARM.
REQ-018 On a fault event with retry_cnt<MAX_RETRIES, the block SHALL increment retry_cnt and enter RECOVER next cycle.
REQ-019 On a fault event with retry_cnt==MAX_RETRIES, the block SHALL enter ALARM next cycle and leave retry_cnt unchanged.
REQ-020 Each fault event SHALL increment fault_cnt by 1, saturating at all-ones.
REQ-021 In RECOVER, resync_o=1 and stall_o=1 SHALL hold for exactly RECOVER_CYCLES cycles, after which the state SHALL be CHECK.
REQ-022 In CHECK, the outputs SHALL be 0; after CHECK_CYCLES fault-free cycles the block SHALL enter IDLE with retry_cnt=0.
REQ-023 In ALARM, alarm_o=1 and stall_o=1 SHALL hold until clear_i=1; then the block SHALL enter IDLE with retry_cnt=0 and fault_cnt unchanged.
REQ-024 clear_i SHALL be ignored outside ALARM; clear_i together with fault_i in ALARM SHALL clear, and that fault SHALL not be counted.
REQ-025 Latency: a fault event at cycle N SHALL be visible on resync_o or alarm_o at cycle N+1.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE, all outputs and counters SHALL be 0, and timers SHALL be cleared, asynchronously, including mid-RECOVER or mid-ALARM.

Configuration
REQ-027 With TMR_FAULT_LOG_EN defined, fault_mask_o SHALL accumulate fault_i on fault events and SHALL be cleared by reset or by clear_i accepted in ALARM.
REQ-028 Without TMR_FAULT_LOG_EN, fault_mask_o SHALL be constant 0 and no logging flops SHALL be present.

Verification (N_VOTERS=4, RECOVER_CYCLES=4, CHECK_CYCLES=8, MAX_RETRIES=2)
REQ-029 fault_i=0010 at cycle 10 only -> resync_o/stall_o=1 cycles 11-14; CHECK 15-22; IDLE at 23 with retry_cnt_o=0 and fault_cnt_o=1.
REQ-030 Fault in each CHECK window, three times -> retry_cnt_o reaches 2; third fault gives alarm_o=1 next cycle; fault_cnt_o=3; alarm_o holds for 100 cycles without clear_i.
REQ-031 In ALARM, clear_i=1 with fault_i=1111 in the same cycle -> IDLE next cycle, alarm_o=0, stall_o=0, fault_cnt_o unchanged.
REQ-032 CNT_WIDTH=4 with 20 fault events (each episode cleared) -> fault_cnt_o=15 and holds.
REQ-033 rst_n driven low at the second RECOVER cycle -> resync_o, stall_o and all counters read 0 before the next clock edge.
REQ-034 With TMR_FAULT_LOG_EN: faults 0001 then 0100 -> fault_mask_o=0101; cleared after clear_i in ALARM. Without the macro -> fault_mask_o=0000 throughout.

Source files
------------

// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// Purpose : recovery/alarm controller fed by the TMR voters' faulty flags.
//           It resyncs the replicas, watches a fault-free window afterwards, and
//           raises a sticky alarm once the retries for one episode are used up.
// Latency : a fault event in cycle N shows on resync_o or alarm_o in cycle N+1.
//           resync_o, stall_o and alarm_o are decoded from the state register only.
// Backpr. : none. stall_o holds the pipeline while recovering or alarmed.
//           fault_i is ignored in RECOVER and ALARM.
//
// Ports   : clk, rst_n (async, active-low)
//           fault_i[N_VOTERS]  per-voter faulty flag
//           clear_i            clears the alarm; only acted on in ALARM
//           resync_o, stall_o, alarm_o
//           retry_cnt_o[4]     recoveries in the current fault episode
//           fault_cnt_o        saturating count of all fault events
//           fault_mask_o       sticky OR of the voters that faulted
// Option  : TMR_FAULT_LOG_EN enables the fault_mask_o logging flops.
//           Without it, fault_mask_o is tied to 0.
module cv32e40p_tmr_fault_ctrl #(
    parameter int N_VOTERS       = 4,
    parameter int RECOVER_CYCLES = 4,
    parameter int CHECK_CYCLES   = 8,
    parameter int MAX_RETRIES    = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_VOTERS-1:0]  fault_i,
    input  logic                 clear_i,
    output logic                 resync_o,
    output logic                 stall_o,
    output logic                 alarm_o,
    output logic [3:0]           retry_cnt_o,
    output logic [CNT_WIDTH-1:0] fault_cnt_o,
    output logic [N_VOTERS-1:0]  fault_mask_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        CHECK   = 2'd2,
        ALARM   = 2'd3
    } state_t;

    localparam logic [7:0] REC_LAST = 8'(RECOVER_CYCLES - 1);
    localparam logic [7:0] CHK_LAST = 8'(CHECK_CYCLES - 1);
    localparam logic [3:0] MAX_RTY  = 4'(MAX_RETRIES);

    state_t               state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic [3:0]           retry_q, retry_d;
    logic [CNT_WIDTH-1:0] fault_cnt_q;
    logic                 fault_evt;

    // Only IDLE and CHECK observe the voters. In RECOVER the replicas are being
    // rewritten, and in ALARM the episode is already decided.
    assign fault_evt = (|fault_i) && ((state_q == IDLE) || (state_q == CHECK));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        case (state_q)
            IDLE, CHECK: begin
                if (fault_evt) begin
                    timer_d = '0;
                    if (retry_q < MAX_RTY) begin
                        retry_d = retry_q + 4'd1;
                        state_d = RECOVER;
                    end else begin
                        state_d = ALARM;
                    end
                end else if (state_q == CHECK) begin
                    if (timer_q == CHK_LAST) begin
                        timer_d = '0;
                        retry_d = '0;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            RECOVER: begin
                if (timer_q == REC_LAST) begin
                    timer_d = '0;
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ALARM: begin
                if (clear_i) begin
                    retry_d = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                retry_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    // Total event count survives alarm clears; only reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= '0;
        end else if (fault_evt && (fault_cnt_q != {CNT_WIDTH{1'b1}})) begin
            fault_cnt_q <= fault_cnt_q + 1'b1;
        end
    end

`ifdef TMR_FAULT_LOG_EN
    logic [N_VOTERS-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (fault_evt) begin
            mask_q <= mask_q | fault_i;
        end else if ((state_q == ALARM) && clear_i) begin
            mask_q <= '0;
        end
    end

    assign fault_mask_o = mask_q;
`else
    assign fault_mask_o = '0;
`endif

    assign resync_o    = (state_q == RECOVER);
    assign stall_o     = (state_q == RECOVER) || (state_q == ALARM);
    assign alarm_o     = (state_q == ALARM);
    assign retry_cnt_o = retry_q;
    assign fault_cnt_o = fault_cnt_q;

endmodule
